// File: rtl/uart_pkg.sv
// Shared UART constants: default data width and default receive FIFO depth,
// used by uart_rx, the transmit path and uart_rx_fifo so they stay in agreement.
package uart_pkg;

  localparam int unsigned DATA_LENGTH = 8;
  localparam int unsigned FIFO_DEPTH  = 16;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned fifo_level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Storage array for uart_rx_fifo: one clocked write port, one asynchronous
// read port. Depth must be a power of two and at least 2.
module uart_fifo_mem #(
  parameter int unsigned DataLength = 8,
  parameter int unsigned Depth      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_wr_en,
  input  logic [$clog2(Depth)-1:0]   i_wr_addr,
  input  logic [DataLength-1:0]      i_wr_data,
  input  logic [$clog2(Depth)-1:0]   i_rd_addr,
  output logic [DataLength-1:0]      o_rd_data
);

  logic [DataLength-1:0] mem_q [Depth];

  // Write the addressed entry on an accepted push.
  // NOTE: the array has no reset on purpose; the pointers and count define which
  // entries are meaningful, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive FIFO placed behind uart_rx: first-word-fall-through read side,
// drops pushes while full and records that in a sticky overflow flag.
// Optional feature: define UART_FIFO_LEVEL_EN to add the o_level occupancy port.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DataLength = DATA_LENGTH,
  parameter int unsigned Depth      = FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [DataLength-1:0]    i_wr_data,
  input  logic                     i_wr_en,
  output logic                     o_full,
  output logic [DataLength-1:0]    o_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic                     o_overflow
`ifdef UART_FIFO_LEVEL_EN
  ,
  output logic [$clog2(Depth):0]   o_level
`endif
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = fifo_level_width(Depth);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            push, pop, drop;

  // Status comes straight from the registered count, so a word pushed into an
  // empty FIFO becomes visible (and poppable) one cycle later.
  assign o_full     = (count_q == CntW'(Depth));
  assign o_rd_valid = (count_q != '0);
  assign o_overflow = overflow_q;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  // Gating with reset keeps the storage untouched during a reset cycle.
  assign push = i_rst_n & i_wr_en & ~o_full;
  assign drop = i_wr_en & o_full;
  assign pop  = o_rd_valid & i_rd_ready;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  // NOTE: every _d gets a default before any branch, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset; the reset branch wins
  // over any push or pop presented in the same cycle.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  uart_fifo_mem #(
    .DataLength (DataLength),
    .Depth      (Depth)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (push),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_wr_data),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (o_rd_data)
  );

`ifdef UART_FIFO_LEVEL_EN
  assign o_level = count_q;
`endif

endmodule : uart_rx_fifo
